// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2
    } state_e;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

endpackage

// File: rtl/hazard_controller_if.sv
// Per-operand forwarding bus: E-stage source plus the M/W writers it may bypass from.
interface hazard_controller_if #(
    parameter int READ_DATA_WIDTH = 5
);
    logic [READ_DATA_WIDTH-1:0] rs_e;
    logic [READ_DATA_WIDTH-1:0] rd_m;
    logic [READ_DATA_WIDTH-1:0] rd_w;
    logic                       regwrite_m;
    logic                       regwrite_w;
    logic [1:0]                 forward;

    modport master (
        output rs_e, rd_m, rd_w, regwrite_m, regwrite_w,
        input  forward
    );

    modport slave (
        input  rs_e, rd_m, rd_w, regwrite_m, regwrite_w,
        output forward
    );
endinterface

// File: rtl/forwarding_unit.sv
// Operand bypass select for one E-stage source; the younger M-stage writer wins over W.
module forwarding_unit
    import hazard_pkg::*;
(
    hazard_controller_if.slave fwd
);

    always_comb begin
        fwd.forward = FWD_REG;
        if (fwd.regwrite_m && (fwd.rd_m != '0) && (fwd.rd_m == fwd.rs_e)) begin
            fwd.forward = FWD_M;
        end else if (fwd.regwrite_w && (fwd.rd_w != '0) && (fwd.rd_w == fwd.rs_e)) begin
            fwd.forward = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: cache-miss stalls, branch flushes, load-use bubbles,
// operand forwarding and stall/miss performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 5,
    parameter int SRC_WIDTH       = 2,
    parameter int CNT_WIDTH       = 16
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [READ_DATA_WIDTH-1:0] Rs1_d,
    input  logic [READ_DATA_WIDTH-1:0] Rs2_d,
    input  logic [READ_DATA_WIDTH-1:0] Rs1_e,
    input  logic [READ_DATA_WIDTH-1:0] Rs2_e,
    input  logic [READ_DATA_WIDTH-1:0] Rd_e,
    input  logic [READ_DATA_WIDTH-1:0] Rd_m,
    input  logic [READ_DATA_WIDTH-1:0] Rd_w,
    input  logic                       RegWrite_m,
    input  logic                       RegWrite_w,
    input  logic [SRC_WIDTH-1:0]       ResultSrc_e,
    input  logic                       PCSrc_e,
    input  logic                       dmiss_m,
    input  logic                       dready,
    input  logic                       imiss_f,
    input  logic                       iready,
    output logic                       en_f,
    output logic                       en_d,
    output logic                       en_e,
    output logic                       en_m,
    output logic                       flush_n_d,
    output logic                       flush_n_e,
    output logic                       flush_n_m,
    output logic                       flush_n_w,
    output logic                       iabort,
    output logic [1:0]                 ForwardA_e,
    output logic [1:0]                 ForwardB_e,
    output logic [CNT_WIDTH-1:0]       stall_cycles,
    output logic [CNT_WIDTH-1:0]       dmiss_count,
    output state_e                     state_dbg
);

    if (READ_DATA_WIDTH > DATA_WIDTH) begin : g_width_check
        $error("hazard_controller: READ_DATA_WIDTH exceeds DATA_WIDTH");
    end

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0] dmiss_count_q, dmiss_count_d;
    logic                 dmiss_start;
    logic                 load_use;

    hazard_controller_if #(.READ_DATA_WIDTH(READ_DATA_WIDTH)) fwd_a ();
    hazard_controller_if #(.READ_DATA_WIDTH(READ_DATA_WIDTH)) fwd_b ();

    assign fwd_a.rs_e       = Rs1_e;
    assign fwd_a.rd_m       = Rd_m;
    assign fwd_a.rd_w       = Rd_w;
    assign fwd_a.regwrite_m = RegWrite_m;
    assign fwd_a.regwrite_w = RegWrite_w;
    assign fwd_b.rs_e       = Rs2_e;
    assign fwd_b.rd_m       = Rd_m;
    assign fwd_b.rd_w       = Rd_w;
    assign fwd_b.regwrite_m = RegWrite_m;
    assign fwd_b.regwrite_w = RegWrite_w;

    forwarding_unit u_fwd_a (.fwd(fwd_a.slave));
    forwarding_unit u_fwd_b (.fwd(fwd_b.slave));

    assign ForwardA_e = fwd_a.forward;
    assign ForwardB_e = fwd_b.forward;

    assign load_use = (ResultSrc_e == SRC_WIDTH'(RESULTSRC_LOAD)) && (Rd_e != '0) &&
                      ((Rd_e == Rs1_d) || (Rd_e == Rs2_d));

    // dready/iready are single-cycle refill-done pulses; they only act in the
    // state waiting for them and are dropped anywhere else.
    always_comb begin
        state_d     = state_q;
        en_f        = 1'b1;
        en_d        = 1'b1;
        en_e        = 1'b1;
        en_m        = 1'b1;
        flush_n_d   = 1'b1;
        flush_n_e   = 1'b1;
        flush_n_m   = 1'b1;
        flush_n_w   = 1'b1;
        iabort      = 1'b0;
        dmiss_start = 1'b0;
        if (rst) begin
            state_d   = RUN;
            flush_n_d = 1'b0;
            flush_n_e = 1'b0;
            flush_n_m = 1'b0;
            flush_n_w = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dmiss_m) begin
                        state_d     = DWAIT;
                        dmiss_start = 1'b1;
                        {en_f, en_d, en_e, en_m} = 4'b0000;
                        flush_n_w   = 1'b0;
                    end else if (PCSrc_e) begin
                        flush_n_d = 1'b0;
                        flush_n_e = 1'b0;
                    end else if (imiss_f) begin
                        state_d   = IWAIT;
                        en_f      = 1'b0;
                        flush_n_d = 1'b0;
                    end else if (load_use) begin
                        en_f      = 1'b0;
                        en_d      = 1'b0;
                        flush_n_e = 1'b0;
                    end
                end
                DWAIT: begin
                    if (dready) begin
                        state_d = RUN;
                    end else begin
                        {en_f, en_d, en_e, en_m} = 4'b0000;
                        flush_n_w = 1'b0;
                    end
                end
                IWAIT: begin
                    // The pending fetch miss is dropped here and re-raised by imiss_f later.
                    if (dmiss_m) begin
                        state_d = DWAIT;
                        {en_f, en_d, en_e, en_m} = 4'b0000;
                        flush_n_w = 1'b0;
                    end else if (PCSrc_e) begin
                        state_d   = RUN;
                        iabort    = 1'b1;
                        flush_n_d = 1'b0;
                        flush_n_e = 1'b0;
                    end else if (iready) begin
                        state_d = RUN;
                    end else begin
                        en_f      = 1'b0;
                        flush_n_d = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        dmiss_count_d  = dmiss_count_q;
        if (!en_f && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
        end
        if (dmiss_start && (dmiss_count_q != '1)) begin
            dmiss_count_d = dmiss_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
            dmiss_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
            dmiss_count_q  <= dmiss_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign dmiss_count  = dmiss_count_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized cycles against a rule model.
module tb_hazard_controller;
    import hazard_pkg::*;

    localparam int M_RUN = 0;
    localparam int M_DATA = 1;
    localparam int M_INSTR = 2;

    typedef struct {
        logic [3:0] en;
        logic [3:0] fl;
        logic       iab;
        int         nxt;
        logic       dm_inc;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1_d, Rs2_d, Rs2_e, Rd_e;
    logic [1:0] ResultSrc_e;
    logic       PCSrc_e, dmiss_m, dready, imiss_f, iready;
    logic       en_f, en_d, en_e, en_m;
    logic       flush_n_d, flush_n_e, flush_n_m, flush_n_w;
    logic       iabort;
    logic [1:0] ForwardB_e;
    logic [15:0] stall_cycles, dmiss_count;
    state_e     state_dbg;
    logic [3:0] en_v, fl_v;

    int n_checks = 0;
    int n_errors = 0;

    hazard_controller_if #(.READ_DATA_WIDTH(5)) fa_bus ();

    hazard_controller dut (
        .clk(clk), .rst(rst),
        .Rs1_d(Rs1_d), .Rs2_d(Rs2_d),
        .Rs1_e(fa_bus.rs_e), .Rs2_e(Rs2_e), .Rd_e(Rd_e),
        .Rd_m(fa_bus.rd_m), .Rd_w(fa_bus.rd_w),
        .RegWrite_m(fa_bus.regwrite_m), .RegWrite_w(fa_bus.regwrite_w),
        .ResultSrc_e(ResultSrc_e), .PCSrc_e(PCSrc_e),
        .dmiss_m(dmiss_m), .dready(dready), .imiss_f(imiss_f), .iready(iready),
        .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m),
        .flush_n_d(flush_n_d), .flush_n_e(flush_n_e),
        .flush_n_m(flush_n_m), .flush_n_w(flush_n_w),
        .iabort(iabort),
        .ForwardA_e(fa_bus.forward), .ForwardB_e(ForwardB_e),
        .stall_cycles(stall_cycles), .dmiss_count(dmiss_count),
        .state_dbg(state_dbg)
    );

    assign en_v = {en_f, en_d, en_e, en_m};
    assign fl_v = {flush_n_d, flush_n_e, flush_n_m, flush_n_w};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Rs1_d = 0; Rs2_d = 0; Rs2_e = 0; Rd_e = 0;
        fa_bus.rs_e = 0; fa_bus.rd_m = 0; fa_bus.rd_w = 0;
        fa_bus.regwrite_m = 0; fa_bus.regwrite_w = 0;
        ResultSrc_e = 0; PCSrc_e = 0;
        dmiss_m = 0; dready = 0; imiss_f = 0; iready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] fwd_ref(logic [4:0] rs, logic [4:0] rdm, logic [4:0] rdw,
                                           logic rwm, logic rww);
        if (rwm && rdm != 0 && rdm == rs) return 2'b10;
        if (rww && rdw != 0 && rdw == rs) return 2'b01;
        return 2'b00;
    endfunction

    // en = {f,d,e,m}, fl = {d,e,m,w}; built from the priority rules, highest first.
    function automatic ctl_t rule_ctl(int mode);
        ctl_t c;
        logic lu;
        c.en = 4'b1111; c.fl = 4'b1111; c.iab = 1'b0; c.nxt = mode; c.dm_inc = 1'b0;
        lu = (ResultSrc_e == 2'b01) && (Rd_e != 0) && (Rd_e == Rs1_d || Rd_e == Rs2_d);
        if (rst) begin
            c.fl = 4'b0000;
            c.nxt = M_RUN;
        end else if (mode == M_DATA) begin
            if (dready) c.nxt = M_RUN;
            else begin c.en = 4'b0000; c.fl = 4'b1110; end
        end else if (dmiss_m) begin
            c.en = 4'b0000; c.fl = 4'b1110; c.nxt = M_DATA;
            c.dm_inc = (mode == M_RUN);
        end else if (PCSrc_e) begin
            c.fl = 4'b0011; c.nxt = M_RUN;
            c.iab = (mode == M_INSTR);
        end else if (mode == M_INSTR) begin
            if (iready) c.nxt = M_RUN;
            else begin c.en = 4'b0111; c.fl = 4'b0111; end
        end else if (imiss_f) begin
            c.en = 4'b0111; c.fl = 4'b0111; c.nxt = M_INSTR;
        end else if (lu) begin
            c.en = 4'b0011; c.fl = 4'b1011;
        end
        return c;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        dmiss_m = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b0000 || iabort !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: en=%b fl=%b iabort=%b, want en=1111 fl=0000 iabort=0", en_v, fl_v, iabort);
        end
        tick();
        tick();
        n_checks++;
        if (state_dbg !== RUN || stall_cycles !== 16'd0 || dmiss_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d stall=%0d dmiss=%0d, want RUN 0 0", state_dbg, stall_cycles, dmiss_count);
        end
        rst = 1'b0;
        dmiss_m = 1'b0;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b1111) begin
            n_errors++;
            $display("FAIL reset_release: en=%b fl=%b, want 1111 1111", en_v, fl_v);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrc_e = 2'b01; Rd_e = 5; Rs1_d = 5; Rs2_d = 9;
        #1;
        n_checks++;
        if (en_v !== 4'b0011 || fl_v !== 4'b1011) begin
            n_errors++;
            $display("FAIL load_use_stall: en=%b fl=%b, want en=0011 fl=1011", en_v, fl_v);
        end
        tick();
        ResultSrc_e = 2'b00;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b1111 || stall_cycles !== 16'd1) begin
            n_errors++;
            $display("FAIL load_use_release: en=%b fl=%b stall=%0d, want 1111 1111 1", en_v, fl_v, stall_cycles);
        end
        ResultSrc_e = 2'b01; Rd_e = 0; Rs1_d = 0; Rs2_d = 0;
        #1;
        n_checks++;
        if (en_v !== 4'b1111) begin
            n_errors++;
            $display("FAIL load_use_x0: en=%b, want 1111", en_v);
        end
        Rd_e = 12; Rs1_d = 3; Rs2_d = 12;
        #1;
        n_checks++;
        if (en_v !== 4'b0011 || fl_v !== 4'b1011) begin
            n_errors++;
            $display("FAIL load_use_rs2: en=%b fl=%b, want 0011 1011", en_v, fl_v);
        end
        idle_inputs();
    endtask

    task automatic test_dmiss();
        do_reset();
        dmiss_m = 1'b1;
        for (int i = 0; i < 5; i++) begin
            // stray refill/branch inputs while waiting must be ignored
            iready = (i == 2);
            PCSrc_e = (i == 3);
            #1;
            n_checks++;
            if (en_v !== 4'b0000 || fl_v !== 4'b1110 || iabort !== 1'b0) begin
                n_errors++;
                $display("FAIL dmiss_stall_%0d: en=%b fl=%b iabort=%b, want 0000 1110 0", i, en_v, fl_v, iabort);
            end
            tick();
        end
        iready = 1'b0; PCSrc_e = 1'b0;
        dready = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b1111) begin
            n_errors++;
            $display("FAIL dmiss_dready: en=%b fl=%b, want 1111 1111", en_v, fl_v);
        end
        tick();
        dready = 1'b0; dmiss_m = 1'b0;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || dmiss_count !== 16'd1 || stall_cycles !== 16'd5) begin
            n_errors++;
            $display("FAIL dmiss_counters: en=%b dmiss=%0d stall=%0d, want 1111 1 5", en_v, dmiss_count, stall_cycles);
        end
    endtask

    task automatic test_iwait_branch();
        do_reset();
        imiss_f = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b0111 || fl_v !== 4'b0111) begin
            n_errors++;
            $display("FAIL imiss_enter: en=%b fl=%b, want 0111 0111", en_v, fl_v);
        end
        tick();
        dready = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b0111 || fl_v !== 4'b0111 || iabort !== 1'b0) begin
            n_errors++;
            $display("FAIL iwait_hold: en=%b fl=%b iabort=%b, want 0111 0111 0", en_v, fl_v, iabort);
        end
        tick();
        dready = 1'b0;
        PCSrc_e = 1'b1;
        #1;
        n_checks++;
        if (iabort !== 1'b1 || en_v !== 4'b1111 || fl_v !== 4'b0011) begin
            n_errors++;
            $display("FAIL iwait_branch: iabort=%b en=%b fl=%b, want 1 1111 0011", iabort, en_v, fl_v);
        end
        tick();
        PCSrc_e = 1'b0; imiss_f = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== RUN || en_v !== 4'b1111 || iabort !== 1'b0) begin
            n_errors++;
            $display("FAIL iwait_branch_after: state=%0d en=%b iabort=%b, want RUN 1111 0", state_dbg, en_v, iabort);
        end
        imiss_f = 1'b1;
        tick();
        iready = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b1111) begin
            n_errors++;
            $display("FAIL iwait_iready: en=%b fl=%b, want 1111 1111", en_v, fl_v);
        end
        tick();
        iready = 1'b0; imiss_f = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== RUN || stall_cycles !== 16'd3) begin
            n_errors++;
            $display("FAIL iwait_iready_after: state=%0d stall=%0d, want RUN 3", state_dbg, stall_cycles);
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] want;
        idle_inputs();
        fa_bus.rd_m = 7; fa_bus.rd_w = 7; fa_bus.regwrite_m = 1; fa_bus.regwrite_w = 1;
        fa_bus.rs_e = 7;
        #1;
        n_checks++;
        if (fa_bus.forward !== 2'b10) begin
            n_errors++;
            $display("FAIL fwd_m_priority: got %b want 10", fa_bus.forward);
        end
        fa_bus.rd_m = 0;
        #1;
        n_checks++;
        if (fa_bus.forward !== 2'b01) begin
            n_errors++;
            $display("FAIL fwd_w: got %b want 01", fa_bus.forward);
        end
        fa_bus.rs_e = 0; fa_bus.rd_w = 0;
        #1;
        n_checks++;
        if (fa_bus.forward !== 2'b00) begin
            n_errors++;
            $display("FAIL fwd_x0: got %b want 00", fa_bus.forward);
        end
        for (int i = 0; i < 40; i++) begin
            fa_bus.rs_e = 5'($urandom_range(0, 3));
            Rs2_e = 5'($urandom_range(0, 3));
            fa_bus.rd_m = 5'($urandom_range(0, 3));
            fa_bus.rd_w = 5'($urandom_range(0, 3));
            fa_bus.regwrite_m = 1'($urandom_range(0, 1));
            fa_bus.regwrite_w = 1'($urandom_range(0, 1));
            #1;
            want = fwd_ref(Rs2_e, fa_bus.rd_m, fa_bus.rd_w, fa_bus.regwrite_m, fa_bus.regwrite_w);
            n_checks++;
            if (ForwardB_e !== want) begin
                n_errors++;
                $display("FAIL fwd_b_rand_%0d: got %b want %b", i, ForwardB_e, want);
            end
        end
        idle_inputs();
    endtask

    task automatic test_loaduse_branch();
        do_reset();
        ResultSrc_e = 2'b01; Rd_e = 4; Rs1_d = 4; PCSrc_e = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b0011 || iabort !== 1'b0) begin
            n_errors++;
            $display("FAIL lu_branch: en=%b fl=%b iabort=%b, want 1111 0011 0", en_v, fl_v, iabort);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_errors++;
            $display("FAIL lu_branch_stall_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_reset_in_dwait();
        do_reset();
        dmiss_m = 1'b1;
        tick();
        tick();
        dmiss_m = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (en_v !== 4'b1111 || fl_v !== 4'b0000) begin
            n_errors++;
            $display("FAIL rst_dwait_during: en=%b fl=%b, want 1111 0000", en_v, fl_v);
        end
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== RUN || stall_cycles !== 16'd0 || dmiss_count !== 16'd0 ||
            en_v !== 4'b1111 || fl_v !== 4'b1111) begin
            n_errors++;
            $display("FAIL rst_dwait_after: state=%0d stall=%0d dmiss=%0d en=%b fl=%b, want RUN 0 0 1111 1111",
                     state_dbg, stall_cycles, dmiss_count, en_v, fl_v);
        end
    endtask

    task automatic test_random();
        ctl_t c;
        int mode = M_RUN;
        int exp_stall = 0;
        int exp_dmc = 0;
        logic [1:0] want_a, want_b;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 49) == 0);
            dmiss_m = ($urandom_range(0, 7) == 0);
            dready = ($urandom_range(0, 2) == 0);
            imiss_f = ($urandom_range(0, 4) == 0);
            iready = ($urandom_range(0, 2) == 0);
            PCSrc_e = ($urandom_range(0, 5) == 0);
            ResultSrc_e = 2'($urandom_range(0, 3));
            Rd_e = 5'($urandom_range(0, 3));
            Rs1_d = 5'($urandom_range(0, 3));
            Rs2_d = 5'($urandom_range(0, 3));
            Rs2_e = 5'($urandom_range(0, 3));
            fa_bus.rs_e = 5'($urandom_range(0, 3));
            fa_bus.rd_m = 5'($urandom_range(0, 3));
            fa_bus.rd_w = 5'($urandom_range(0, 3));
            fa_bus.regwrite_m = 1'($urandom_range(0, 1));
            fa_bus.regwrite_w = 1'($urandom_range(0, 1));
            #1;
            c = rule_ctl(mode);
            want_a = fwd_ref(fa_bus.rs_e, fa_bus.rd_m, fa_bus.rd_w, fa_bus.regwrite_m, fa_bus.regwrite_w);
            want_b = fwd_ref(Rs2_e, fa_bus.rd_m, fa_bus.rd_w, fa_bus.regwrite_m, fa_bus.regwrite_w);
            n_checks++;
            if (en_v !== c.en) begin
                n_errors++;
                $display("FAIL rand_en cyc %0d: got %b want %b", cyc, en_v, c.en);
            end
            n_checks++;
            if (fl_v !== c.fl) begin
                n_errors++;
                $display("FAIL rand_flush cyc %0d: got %b want %b", cyc, fl_v, c.fl);
            end
            n_checks++;
            if (iabort !== c.iab) begin
                n_errors++;
                $display("FAIL rand_iabort cyc %0d: got %b want %b", cyc, iabort, c.iab);
            end
            n_checks++;
            if (fa_bus.forward !== want_a || ForwardB_e !== want_b) begin
                n_errors++;
                $display("FAIL rand_fwd cyc %0d: got A=%b B=%b want A=%b B=%b", cyc, fa_bus.forward, ForwardB_e, want_a, want_b);
            end
            n_checks++;
            if (stall_cycles !== 16'(exp_stall)) begin
                n_errors++;
                $display("FAIL rand_stall_cnt cyc %0d: got %0d want %0d", cyc, stall_cycles, exp_stall);
            end
            n_checks++;
            if (dmiss_count !== 16'(exp_dmc)) begin
                n_errors++;
                $display("FAIL rand_dmiss_cnt cyc %0d: got %0d want %0d", cyc, dmiss_count, exp_dmc);
            end
            if (rst) begin
                exp_stall = 0;
                exp_dmc = 0;
            end else begin
                if (!c.en[3] && exp_stall < 65535) exp_stall++;
                if (c.dm_inc && exp_dmc < 65535) exp_dmc++;
            end
            mode = c.nxt;
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_dmiss();
        test_iwait_branch();
        test_forwarding();
        test_loaduse_branch();
        test_reset_in_dwait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 32 (datapath width); READ_DATA_WIDTH 5 (register index width); SRC_WIDTH 2 (ResultSrc width); CNT_WIDTH 16 (performance counter width).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- Rs1_d, Rs2_d  in  READ_DATA_WIDTH  decode-stage source registers.
- Rs1_e, Rs2_e, Rd_e  in  READ_DATA_WIDTH  execute-stage sources and destination.
- Rd_m, Rd_w  in  READ_DATA_WIDTH  memory-stage and writeback-stage destinations.
- RegWrite_m, RegWrite_w  in  1  register-write flags for M and W.
- ResultSrc_e  in  SRC_WIDTH  execute result source; 2'b01 = load.
- PCSrc_e  in  1  branch/jump taken in E.
- dmiss_m  in  1  data cache miss on the M-stage access.
- dready  in  1  data refill complete, 1-cycle pulse.
- imiss_f  in  1  instruction cache miss in F.
- iready  in  1  instruction refill complete, 1-cycle pulse.
- en_f, en_d, en_e, en_m  out  1  pipeline-register enables; 0 = stall.
- flush_n_d, flush_n_e, flush_n_m, flush_n_w  out  1  pipeline-register flushes, active-low.
- iabort  out  1  cancels the outstanding instruction refill.
- ForwardA_e, ForwardB_e  out  2  operand forward select.
- stall_cycles, dmiss_count  out  CNT_WIDTH  performance counters.

Function
REQ-003 SHALL implement FSM states RUN, DWAIT, IWAIT.
REQ-004 SHALL apply FSM priority, highest first: dmiss_m, PCSrc_e, imiss_f, load-use.
REQ-005 In RUN with dmiss_m=1: SHALL go to DWAIT and drive en_f/d/e/m=0 and flush_n_w=0 in the same cycle.
REQ-006 In DWAIT: SHALL hold en_f/d/e/m=0 and flush_n_w=0; on dready=1, SHALL drive all enables 1 in that cycle and move to RUN.
REQ-007 In RUN with imiss_f=1 and no dmiss_m: SHALL go to IWAIT and drive en_f=0 and flush_n_d=0; the rest of the pipe advances.
REQ-008 In IWAIT: SHALL hold en_f=0 and flush_n_d=0; on iready=1, SHALL drive en_f=1 and move to RUN.
REQ-009 PCSrc_e=1 in RUN or IWAIT SHALL drive flush_n_d=0, flush_n_e=0 and en_f=1. In IWAIT it SHALL also pulse iabort=1 and move to RUN.
REQ-010 dmiss_m=1 in IWAIT SHALL move to DWAIT; the instruction miss is re-evaluated from imiss_f after return to RUN.
REQ-011 Load-use SHALL be detected when ResultSrc_e==2'b01, Rd_e!=0, and Rd_e equals Rs1_d or Rs2_d. In RUN with no higher-priority event, it SHALL drive en_f=0, en_d=0, flush_n_e=0 for one cycle.
REQ-012 Simultaneous load-use and PCSrc_e: the branch wins, with no stall.
REQ-013 ForwardA_e SHALL be combinational:
- 2'b10 if RegWrite_m, Rd_m!=0 and Rd_m==Rs1_e.
- otherwise 2'b01 if RegWrite_w, Rd_w!=0 and Rd_w==Rs1_e.
- otherwise 2'b00.
REQ-014 ForwardB_e SHALL follow the same rule using Rs2_e.
REQ-015 All outputs not driven by an active rule SHALL be inactive: enables 1, flush_n 1, iabort 0.
REQ-016 stall_cycles SHALL increment every cycle en_f=0 and saturate at all-ones.
REQ-017 dmiss_count SHALL increment on each RUN->DWAIT transition and saturate at all-ones.
REQ-018 dready/iready arriving in a state that is not waiting for them SHALL be ignored.

Reset
REQ-019 While rst=1: state=RUN, counters=0, all flush_n_*=0, all en_*=1, iabort=0.
REQ-020 Reset asserted mid-DWAIT or mid-IWAIT SHALL abandon the wait; no pending miss is remembered.

Structure
REQ-021 hazard_pkg SHALL hold: the FSM state enum; the RESULTSRC_LOAD constant; the FWD_REG/FWD_W/FWD_M encodings.
REQ-022 Forwarding logic SHALL be one sub-module, forwarding_unit, instantiated once per operand.

Verification
REQ-023 Load x5 in E with Rs1_d=5 -> one cycle en_f=0, en_d=0, flush_n_e=0, then normal; stall_cycles=1.
REQ-024 dmiss_m=1, dready after 4 cycles -> en_f/d/e/m=0 and flush_n_w=0 for 5 cycles; dmiss_count=1.
REQ-025 IWAIT, then PCSrc_e=1 -> iabort=1, flush_n_d=0, flush_n_e=0, en_f=1; state RUN next cycle.
REQ-026 Rd_m=Rd_w=7, both RegWrite, Rs1_e=7 -> ForwardA_e=2'b10; with Rd_m=0 -> 2'b01; with Rs1_e=0 -> 2'b00.
REQ-027 Load-use together with PCSrc_e=1 -> no stall; flush_n_d=0, flush_n_e=0.
REQ-028 rst asserted during DWAIT -> next cycle RUN, counters 0, en_*=1.
